riscv_multicycle_control: RTL
=============================

RISCV_MULTICYCLE_CONTROL -- requirements
Module: riscv_multicycle_control

Interface
REQ-001 Parameter XLEN, default RISCV_XLEN (32), instruction width.
REQ-002 Parameter INSTRET_W, default 32, width of the retired-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 instruction  input  XLEN  instruction register contents, decoded with the package Instruction type.
REQ-006 iReady  input  1  instruction memory has valid data this cycle.
REQ-007 dReady  input  1  data memory access completes this cycle.
REQ-008 Zero  input  1  ALU zero flag from the datapath.
REQ-009 Outputs, each 1 bit: PCWrite, IRWrite, PCSrc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, error (sticky illegal-instruction flag).
REQ-010 ALUCtrl  output  ALUOp  ALU operation select.
REQ-011 instret  output  INSTRET_W  count of retired instructions.

Function
REQ-012 FSM states SHALL be FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, ERROR.
REQ-013 FETCH: IRWrite = iReady; stay in FETCH while iReady=0; go to DECODE when iReady=1.
REQ-014 DECODE: one cycle; OP/IMM/L/S/BRANCH go to EXECUTE; any other opcode goes to ERROR.
REQ-015 EXECUTE OP/IMM: ALUCtrl by funct3: ADD/SUB (SUB only for OP with funct7 alternate), SLT, XOR, OR, AND; ALUSrc=1 for IMM only; go to WRITEBACK.
REQ-016 EXECUTE L/S: ALUCtrl=ALU_ADD, ALUSrc=1; go to MEMORY.
REQ-017 EXECUTE BRANCH: BEQ/BNE use ALU_SUB; BLT/BGE use ALU_SLT; ALUSrc=0.
REQ-018 Branch taken: BEQ on Zero, BNE on !Zero, BLT on !Zero, BGE on Zero.
REQ-019 Branch retire: PCSrc = taken; PCWrite=1; go to FETCH.
REQ-020 Any other branch funct3 goes to ERROR.
REQ-021 MEMORY: MemRead (L) or MemWrite (S) held high until dReady.
REQ-022 MEMORY on dReady: L goes to WRITEBACK; S asserts PCWrite and goes to FETCH.
REQ-023 WRITEBACK: RegWrite=1, MemtoReg=1 for L only, PCWrite=1, go to FETCH.
REQ-024 Latency with zero wait: branch 3 cycles, ALU 4, store 4, load 5; each memory wait cycle adds 1.
REQ-025 instret SHALL increment by 1 in the cycle PCWrite=1 and wrap from all-ones to 0.
REQ-026 ERROR: error=1, all other outputs 0, FSM stays until reset.
REQ-027 Outputs not explicitly driven in a state SHALL be 0; ALUCtrl defaults to ALU_ADD.
REQ-028 dReady outside MEMORY and iReady outside FETCH SHALL be ignored.

Reset
REQ-029 rst=0 at a clock edge SHALL force FETCH, instret=0, error=0; this applies mid-operation, including during MEMORY with MemRead/MemWrite high.
REQ-030 All control outputs SHALL be 0 during and immediately after reset, except IRWrite, which follows iReady in FETCH.

Configuration
REQ-031 Macro RISCV_MC_JUMP_EN defined: JAL goes DECODE->WRITEBACK; JALR goes DECODE->EXECUTE (ALU_ADD, ALUSrc=1)->WRITEBACK.
REQ-032 With RISCV_MC_JUMP_EN defined, WRITEBACK for JAL/JALR asserts RegWrite, PCWrite and PCSrc=1.
REQ-033 Macro RISCV_MC_JUMP_EN undefined: JAL/JALR are illegal and go to ERROR.

Structure
REQ-034 The FSM state enum and branch funct3 constants (BNE, BLT, BGE) SHALL be added to riscv_core_p alongside ALUOp and the opcodes.
REQ-035 Decode SHALL be a combinational sub-module riscv_mc_decode (instruction -> instruction class, ALUCtrl, ALUSrc, illegal); the FSM, counter and output registers stay in the top module.

Verification
REQ-036 add x1,x2,x3 (OP, funct7 primary), iReady=1 -> RegWrite=1 and PCWrite=1 in cycle 4 only; instret 0->1.
REQ-037 lw with dReady delayed 3 cycles -> MemRead high 4 cycles, then WRITEBACK with MemtoReg=1; 8 cycles total.
REQ-038 bne with Zero=0 -> ALUCtrl=ALU_SUB, PCSrc=1, PCWrite=1 in cycle 3; with Zero=1 -> PCSrc=0, PCWrite=1.
REQ-039 Opcode 7'b1111111 -> error=1 from cycle 3, outputs quiescent; rst=0 one cycle -> FETCH, error=0.
REQ-040 rst=0 during a store's MEMORY state -> MemWrite=0 the next cycle; instret preloaded to all-ones then one retired add -> instret=0.

Source files
------------

// File: rtl/riscv_multicycle_control_pkg.sv
// Purpose : shared types for the multicycle RISC-V control slice (ALU ops,
//           opcodes, branch funct3 codes, instruction layout, FSM states).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: package riscv_core_p; no ports.
package riscv_core_p;

  localparam int RISCV_XLEN = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_SLT = 3'd2,
    ALU_XOR = 3'd3,
    ALU_OR  = 3'd4,
    ALU_AND = 3'd5
  } ALUOp;

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // funct7 value selecting SUB for register-register ADD
  localparam logic [6:0] F7_ALT = 7'b0100000;

  // ALU funct3 codes
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  // Branch funct3 codes
  localparam logic [2:0] BEQ = 3'b000;
  localparam logic [2:0] BNE = 3'b001;
  localparam logic [2:0] BLT = 3'b100;
  localparam logic [2:0] BGE = 3'b101;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } Instruction;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    ERROR     = 3'd5
  } mc_state_t;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_OP     = 3'd1,
    CLS_IMM    = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_BRANCH = 3'd5,
    CLS_JAL    = 3'd6,
    CLS_JALR   = 3'd7
  } instr_cls_t;

  // ALU select for OP/IMM; sub is only ever set for OP with the alternate funct7.
  function automatic ALUOp alu_from_funct3(input logic [2:0] f3, input logic sub);
    ALUOp op;
    op = ALU_ADD;
    case (f3)
      F3_ADD:  op = sub ? ALU_SUB : ALU_ADD;
      F3_SLT:  op = ALU_SLT;
      F3_XOR:  op = ALU_XOR;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_multicycle_control_decode.sv
// Purpose : combinational instruction decode for the multicycle control FSM.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; outputs follow i_instruction continuously.
// Ports   : i_instruction (IR contents) -> o_cls, o_alu_ctrl, o_alu_src,
//           o_br_on_zero (branch taken when Zero=1), o_illegal.
// Config  : RISCV_MC_JUMP_EN makes JAL/JALR legal; otherwise they decode illegal.
module riscv_mc_decode
  import riscv_core_p::*;
#(
  parameter int XLEN = RISCV_XLEN
) (
  input  logic [XLEN-1:0] i_instruction,
  output instr_cls_t      o_cls,
  output ALUOp            o_alu_ctrl,
  output logic            o_alu_src,
  output logic            o_br_on_zero,
  output logic            o_illegal
);

  Instruction w_instr;
  logic       w_unused_fields;

  assign w_instr         = i_instruction[31:0];
  assign w_unused_fields = ^{w_instr.rs2, w_instr.rs1, w_instr.rd};

  always_comb begin
    o_cls        = CLS_NONE;
    o_alu_ctrl   = ALU_ADD;
    o_alu_src    = 1'b0;
    o_br_on_zero = 1'b0;
    o_illegal    = 1'b0;
    case (w_instr.opcode)
      OPC_OP: begin
        o_cls      = CLS_OP;
        o_alu_ctrl = alu_from_funct3(w_instr.funct3, w_instr.funct7 == F7_ALT);
      end
      OPC_IMM: begin
        o_cls      = CLS_IMM;
        o_alu_ctrl = alu_from_funct3(w_instr.funct3, 1'b0);
        o_alu_src  = 1'b1;
      end
      OPC_LOAD: begin
        o_cls     = CLS_LOAD;
        o_alu_src = 1'b1;
      end
      OPC_STORE: begin
        o_cls     = CLS_STORE;
        o_alu_src = 1'b1;
      end
      OPC_BRANCH: begin
        o_cls = CLS_BRANCH;
        // BLT compares with SLT, so "less than" shows up as a non-zero result.
        case (w_instr.funct3)
          BEQ: begin o_alu_ctrl = ALU_SUB; o_br_on_zero = 1'b1; end
          BNE: begin o_alu_ctrl = ALU_SUB; o_br_on_zero = 1'b0; end
          BLT: begin o_alu_ctrl = ALU_SLT; o_br_on_zero = 1'b0; end
          BGE: begin o_alu_ctrl = ALU_SLT; o_br_on_zero = 1'b1; end
          default: o_illegal = 1'b1;
        endcase
      end
`ifdef RISCV_MC_JUMP_EN
      OPC_JAL: begin
        o_cls = CLS_JAL;
      end
      OPC_JALR: begin
        o_cls     = CLS_JALR;
        o_alu_src = 1'b1;
      end
`else
      OPC_JAL, OPC_JALR: begin
        o_illegal = 1'b1;
      end
`endif
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_control.sv
// Purpose : multicycle RISC-V control unit (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/ERROR).
// Latency : branch 3, ALU 4, store 4, load 5 cycles, plus one per memory wait cycle.
// Backpressure: stalls in FETCH until iReady, in MEMORY until dReady.
// Ports   : clk, rst (sync, active-low), instruction, iReady, dReady, Zero in;
//           PCWrite, IRWrite, PCSrc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
//           error (sticky), ALUCtrl, instret (retired count) out.
// Config  : RISCV_MC_JUMP_EN enables JAL/JALR (handled in riscv_mc_decode).
module riscv_multicycle_control
  import riscv_core_p::*;
#(
  parameter int XLEN      = RISCV_XLEN,
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      instruction,
  input  logic                 iReady,
  input  logic                 dReady,
  input  logic                 Zero,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 PCSrc,
  output logic                 ALUSrc,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 error,
  output ALUOp                 ALUCtrl,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  instr_cls_t w_dec_cls;
  ALUOp       w_dec_alu_ctrl;
  logic       w_dec_alu_src;
  logic       w_dec_br_on_zero;
  logic       w_dec_illegal;

  mc_state_t            r_state;
  instr_cls_t           r_cls;
  ALUOp                 r_alu_ctrl;
  logic                 r_alu_src;
  logic                 r_br_on_zero;
  logic [INSTRET_W-1:0] r_instret;

  riscv_mc_decode #(.XLEN(XLEN)) u_decode (
    .i_instruction (instruction),
    .o_cls         (w_dec_cls),
    .o_alu_ctrl    (w_dec_alu_ctrl),
    .o_alu_src     (w_dec_alu_src),
    .o_br_on_zero  (w_dec_br_on_zero),
    .o_illegal     (w_dec_illegal)
  );

  // State, retire counter and the decode result captured in DECODE, so later
  // states never depend on the instruction input again.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= FETCH;
      r_cls        <= CLS_NONE;
      r_alu_ctrl   <= ALU_ADD;
      r_alu_src    <= 1'b0;
      r_br_on_zero <= 1'b0;
      r_instret    <= '0;
    end else begin
      if (PCWrite) begin
        r_instret <= r_instret + INSTRET_ONE;
      end
      case (r_state)
        FETCH: begin
          if (iReady) r_state <= DECODE;
        end
        DECODE: begin
          r_cls        <= w_dec_cls;
          r_alu_ctrl   <= w_dec_alu_ctrl;
          r_alu_src    <= w_dec_alu_src;
          r_br_on_zero <= w_dec_br_on_zero;
          if (w_dec_illegal)               r_state <= ERROR;
          else if (w_dec_cls == CLS_JAL)   r_state <= WRITEBACK;
          else                             r_state <= EXECUTE;
        end
        EXECUTE: begin
          case (r_cls)
            CLS_BRANCH:          r_state <= FETCH;
            CLS_LOAD, CLS_STORE: r_state <= MEMORY;
            default:             r_state <= WRITEBACK;
          endcase
        end
        MEMORY: begin
          if (dReady) r_state <= (r_cls == CLS_LOAD) ? WRITEBACK : FETCH;
        end
        WRITEBACK: r_state <= FETCH;
        ERROR:     r_state <= ERROR;
        default:   r_state <= ERROR;
      endcase
    end
  end

  assign instret = r_instret;

  // Outputs are decoded from the registered state; IRWrite, PCWrite and PCSrc
  // also look at iReady/dReady/Zero because they must act in the same cycle.
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    PCSrc    = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    error    = 1'b0;
    ALUCtrl  = ALU_ADD;
    case (r_state)
      FETCH: IRWrite = iReady;
      EXECUTE: begin
        ALUCtrl = r_alu_ctrl;
        ALUSrc  = r_alu_src;
        if (r_cls == CLS_BRANCH) begin
          PCWrite = 1'b1;
          PCSrc   = r_br_on_zero ? Zero : !Zero;
        end
      end
      MEMORY: begin
        MemRead  = (r_cls == CLS_LOAD);
        MemWrite = (r_cls == CLS_STORE);
        PCWrite  = dReady && (r_cls == CLS_STORE);
      end
      WRITEBACK: begin
        RegWrite = 1'b1;
        MemtoReg = (r_cls == CLS_LOAD);
        PCWrite  = 1'b1;
        PCSrc    = (r_cls == CLS_JAL) || (r_cls == CLS_JALR);
      end
      ERROR:   error = 1'b1;
      default: ;
    endcase
    // While reset is asserted the state may still be mid-instruction; mask
    // everything so no memory/register write leaks out during that edge.
    if (!rst) begin
      PCWrite  = 1'b0;
      IRWrite  = (r_state == FETCH) && iReady;
      PCSrc    = 1'b0;
      ALUSrc   = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      error    = 1'b0;
      ALUCtrl  = ALU_ADD;
    end
  end

endmodule
